// File: rtl/cavlc_pkg.sv
// cavlc_pkg: shared CAVLC state encoding and coefficient/level width constants
package cavlc_pkg;
  localparam int TC_W        = 5;
  localparam int MAX_COEFF   = 16;
  localparam int LEVEL_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, EMIT, FIN} t1_state_e;
endpackage

// File: rtl/cavlc_trailing_ones.sv
// cavlc_trailing_ones: emits trailing-one sign levels after coeff_token; CAVLC_T1_CHECK_EN enables illegal-token flagging
module cavlc_trailing_ones
  import cavlc_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      TokenValid,
  output logic                      TokenReady,
  input  logic [TC_W-1:0]           TotalCoeff,
  input  logic [1:0]                TrailingOnes,
  input  logic [2:0]                Bits,
  output logic                      Consume,
  output logic [1:0]                ConsumeLen,
  output logic                      LevelValid,
  input  logic                      LevelReady,
  output logic signed [LEVEL_W-1:0] Level,
  output logic [3:0]                LevelIdx,
  output logic                      Done,
  output logic [TC_W-1:0]           Remaining,
  output logic                      SuffixLenInit,
  output logic                      Err
);
  localparam logic [LEVEL_W-1:0] POS = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] NEG = '1;
  t1_state_e  state;
  logic [1:0] t1, nk;
  logic [2:0] bits;
  logic       accept, bad;
  assign TokenReady = state == IDLE;
  assign accept     = TokenValid && TokenReady;
  assign nk         = LevelIdx[1:0] + 2'd1;
`ifdef CAVLC_T1_CHECK_EN
  assign bad = ({3'b0, TrailingOnes} > TotalCoeff) || (TotalCoeff > TC_W'(MAX_COEFF));
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state         <= IDLE;
      t1            <= '0;
      bits          <= '0;
      Consume       <= 1'b0;
      ConsumeLen    <= '0;
      LevelValid    <= 1'b0;
      Level         <= '0;
      LevelIdx      <= '0;
      Done          <= 1'b0;
      Remaining     <= '0;
      SuffixLenInit <= 1'b0;
      Err           <= 1'b0;
    end else begin
      Consume <= 1'b0;
      Done    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && bad) Err <= 1'b1;
          else if (accept) begin
            t1            <= TrailingOnes;
            bits          <= Bits;
            Consume       <= TrailingOnes != 2'd0;
            ConsumeLen    <= TrailingOnes;
            LevelValid    <= TrailingOnes != 2'd0;
            Level         <= Bits[2] ? NEG : POS;
            LevelIdx      <= '0;
            Done          <= TrailingOnes == 2'd0;
            Remaining     <= TotalCoeff - {3'b0, TrailingOnes};
            SuffixLenInit <= (TotalCoeff > 5'd10) && (TrailingOnes < 2'd3);
            state         <= TrailingOnes != 2'd0 ? EMIT : FIN;
          end
        end
        EMIT: begin
          if (LevelReady && LevelIdx[1:0] == t1 - 2'd1) begin
            LevelValid <= 1'b0;
            Done       <= 1'b1;
            state      <= FIN;
          end else if (LevelReady) begin
            LevelIdx <= {2'b0, nk};
            Level    <= bits[2'd2 - nk] ? NEG : POS;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cavlc_trailing_ones.sv
// tb_cavlc_trailing_ones: transaction-queue model plus directed literal checks
module tb_cavlc_trailing_ones;
  logic Clk = 0, Rst_n = 0, TokenValid = 0, LevelReady = 1;
  logic [4:0] TotalCoeff = 0;
  logic [1:0] TrailingOnes = 0;
  logic [2:0] Bits = 0;
  logic TokenReady, Consume, LevelValid, Done, SuffixLenInit, Err;
  logic [1:0] ConsumeLen;
  logic signed [15:0] Level;
  logic [3:0] LevelIdx;
  logic [4:0] Remaining;
  int tests = 0, fails = 0, cyc = 0, last_hs = 0, exp_err = 0;
  typedef struct {int len; int c;} cons_t;
  typedef struct {int lvl; int idx; bit last;} lev_t;
  typedef struct {int rem; int suf; int c;} done_t;
  cons_t cq[$];
  lev_t lq[$];
  done_t dq[$];
  cons_t ce;
  lev_t le;
  done_t de;
  bit stalled = 0;
  int plev = 0, pidx = 0;

  always #5 Clk = ~Clk;

  cavlc_trailing_ones #(.LEVEL_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .TokenValid(TokenValid), .TokenReady(TokenReady),
    .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .Bits(Bits),
    .Consume(Consume), .ConsumeLen(ConsumeLen), .LevelValid(LevelValid),
    .LevelReady(LevelReady), .Level(Level), .LevelIdx(LevelIdx), .Done(Done),
    .Remaining(Remaining), .SuffixLenInit(SuffixLenInit), .Err(Err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    cyc++;
    if (Rst_n) begin
      chk("err", Err, exp_err);
      if (stalled) begin
        chk("hold_valid", LevelValid, 1);
        chk("hold_level", int'(Level), plev);
        chk("hold_idx", int'(LevelIdx), pidx);
      end
      if (Consume) begin
        if (cq.size() == 0) chk("unexp_consume", Consume, 0);
        else begin
          ce = cq.pop_front();
          chk("consume_len", int'(ConsumeLen), ce.len);
          chk("consume_cyc", cyc, ce.c);
        end
      end
      if (LevelValid) begin
        chk("busy_tready", TokenReady, 0);
        if (lq.size() == 0) chk("unexp_level", LevelValid, 0);
        else if (LevelReady) begin
          le = lq.pop_front();
          chk("level", int'(Level), le.lvl);
          chk("level_idx", int'(LevelIdx), le.idx);
          if (le.last) last_hs = cyc;
        end
      end
      if (Done) begin
        if (dq.size() == 0) chk("unexp_done", Done, 0);
        else begin
          de = dq.pop_front();
          chk("remaining", int'(Remaining), de.rem);
          chk("suffix", SuffixLenInit, de.suf);
          chk("done_cyc", cyc, de.c < 0 ? last_hs + 1 : de.c);
        end
      end
      stalled = LevelValid && !LevelReady;
      plev = int'(Level);
      pidx = int'(LevelIdx);
    end else stalled = 0;
  end

  task automatic send(input int tc, input int t1, input logic [2:0] b);
    bit legal = 1;
    int n = 0;
`ifdef CAVLC_T1_CHECK_EN
    legal = !(t1 > tc || tc > 16);
`endif
    while (!TokenReady && n < 100) begin @(posedge Clk); #1; n++; end
    chk("ready_timeout", n < 100, 1);
    TotalCoeff = 5'(tc);
    TrailingOnes = 2'(t1);
    Bits = b;
    TokenValid = 1;
    @(posedge Clk);
    if (legal) begin
      if (t1 > 0) cq.push_back('{t1, cyc + 1});
      for (int k = 0; k < t1; k++) lq.push_back('{b[2-k] ? -1 : 1, k, k == t1 - 1});
      dq.push_back('{tc - t1, int'(tc > 10 && t1 < 3), t1 == 0 ? cyc + 1 : -1});
    end else exp_err = 1;
    #1 TokenValid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cq.size() + lq.size() + dq.size() != 0 || !TokenReady) && n < 100) begin
      @(posedge Clk); #1; n++;
    end
    chk("idle_timeout", n < 100, 1);
  endtask

  task automatic wait_done(input int rem, input int suf);
    int n = 0;
    while (!Done && n < 20) begin @(negedge Clk); n++; end
    chk("done_seen", Done, 1);
    chk("lit_remaining", int'(Remaining), rem);
    chk("lit_suffix", SuffixLenInit, suf);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_tready"}, TokenReady, 1);
    chk({nm, "_consume"}, Consume, 0);
    chk({nm, "_clen"}, int'(ConsumeLen), 0);
    chk({nm, "_lvalid"}, LevelValid, 0);
    chk({nm, "_level"}, int'(Level), 0);
    chk({nm, "_lidx"}, int'(LevelIdx), 0);
    chk({nm, "_done"}, Done, 0);
    chk({nm, "_rem"}, int'(Remaining), 0);
    chk({nm, "_suf"}, SuffixLenInit, 0);
    chk({nm, "_err"}, Err, 0);
  endtask

  int ttc[8] = '{16, 11, 11, 10, 1, 15, 0, 7};
  int tt1[8] = '{3, 2, 3, 1, 1, 2, 0, 3};
  logic [2:0] tbits[8] = '{3'b010, 3'b011, 3'b100, 3'b100, 3'b000, 3'b101, 3'b000, 3'b110};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1 chk_cleared("reset");
    Rst_n = 1;
    @(posedge Clk); #1;
    send(3, 3, 3'b101);
    @(negedge Clk);
    chk("l37_consume", Consume, 1);
    chk("l37_clen", int'(ConsumeLen), 3);
    chk("l37_valid", LevelValid, 1);
    chk("l37_level0", int'(Level), -1);
    chk("l37_idx0", int'(LevelIdx), 0);
    @(negedge Clk);
    chk("l37_level1", int'(Level), 1);
    @(negedge Clk);
    chk("l37_level2", int'(Level), -1);
    chk("l37_idx2", int'(LevelIdx), 2);
    wait_done(0, 0);
    wait_idle();
    send(12, 1, 3'b011);
    @(negedge Clk);
    chk("l38_level", int'(Level), 1);
    wait_done(11, 1);
    wait_idle();
    send(5, 0, 3'b111);
    @(negedge Clk);
    chk("l39_consume", Consume, 0);
    chk("l39_valid", LevelValid, 0);
    chk("l39_done", Done, 1);
    chk("l39_rem", int'(Remaining), 5);
    wait_idle();
    send(0, 0, 3'b000);
    wait_done(0, 0);
    wait_idle();
    LevelReady = 0;
    send(4, 2, 3'b100);
    @(negedge Clk);
    chk("stall_level_a", int'(Level), -1);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    chk("stall_level_b", int'(Level), -1);
    chk("stall_idx", int'(LevelIdx), 0);
    chk("stall_tready", TokenReady, 0);
    @(posedge Clk); #1 LevelReady = 1;
    wait_idle();
    send(16, 3, 3'b010);
    TotalCoeff = 5'd2; TrailingOnes = 2'd1; Bits = 3'b111; TokenValid = 1;
    repeat (2) @(posedge Clk);
    #1 TokenValid = 0;
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      send(ttc[i], tt1[i], tbits[i]);
      wait_idle();
    end
    send(3, 3, 3'b111);
    @(posedge Clk); #1;
    Rst_n = 0;
    cq.delete(); lq.delete(); dq.delete();
    @(posedge Clk); #1;
    chk_cleared("midreset");
    Rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("post_reset_done", Done, 0);
    end
`ifdef CAVLC_T1_CHECK_EN
    send(1, 2, 3'b110);
    repeat (3) @(negedge Clk);
    chk("ill_tready", TokenReady, 1);
    chk("ill_err", Err, 1);
    chk("ill_consume", Consume, 0);
    send(17, 0, 3'b000);
    repeat (3) @(negedge Clk);
    chk("ill_done", Done, 0);
    send(2, 1, 3'b100);
    wait_idle();
    chk("err_sticky", Err, 1);
`endif
    repeat (3) @(posedge Clk);
    chk("queues_empty", cq.size() + lq.size() + dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cavlc_trailing_ones.md
CAVLC_TRAILING_ONES -- requirements
Module: cavlc_trailing_ones

Interface
REQ-001 SHALL have parameter LEVEL_W, default 16, meaning signed level output width.
REQ-002 SHALL have port Clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port TokenValid  input  1  decoded coeff_token present.
REQ-005 SHALL have port TokenReady  output  1  block can accept a token.
REQ-006 SHALL have port TotalCoeff  input  5  coeff_token TotalCoeff, 0..16.
REQ-007 SHALL have port TrailingOnes  input  2  coeff_token TrailingOnes, 0..3.
REQ-008 SHALL have port Bits  input  3  next three bitstream bits after coeff_token; Bits[2] is first in the stream.
REQ-009 SHALL have port Consume  output  1  one-cycle pulse telling the bit shifter to advance.
REQ-010 SHALL have port ConsumeLen  output  2  advance count; valid while Consume=1.
REQ-011 SHALL have port LevelValid  output  1  Level/LevelIdx valid.
REQ-012 SHALL have port LevelReady  input  1  downstream accepts the level.
REQ-013 SHALL have port Level  output  LEVEL_W  signed level, +1 or -1.
REQ-014 SHALL have port LevelIdx  output  4  level index in decode order, starting at 0.
REQ-015 SHALL have port Done  output  1  one-cycle pulse; trailing-ones phase complete.
REQ-016 SHALL have port Remaining  output  5  TotalCoeff-TrailingOnes; valid with Done.
REQ-017 SHALL have port SuffixLenInit  output  1  initial suffixLength for the level decoder; valid with Done.
REQ-018 SHALL have port Err  output  1  sticky illegal-token flag.

Function
REQ-019 SHALL implement FSM states IDLE, EMIT, FIN.
REQ-020 SHALL assert TokenReady only in IDLE; a token is accepted on TokenValid&&TokenReady.
REQ-021 SHALL on acceptance register TotalCoeff, TrailingOnes and Bits, then go to EMIT if TrailingOnes>0, else to FIN.
REQ-022 SHALL pulse Consume in the cycle after acceptance, with ConsumeLen=TrailingOnes; no pulse when TrailingOnes=0.
REQ-023 SHALL in EMIT drive LevelValid=1 starting the cycle after acceptance, so latency is 1 cycle.
REQ-024 SHALL map sign bit k (k=0 is Bits[2], k=1 is Bits[1], k=2 is Bits[0]) to Level=-1 if the bit is 1 and +1 if it is 0, with LevelIdx=k.
REQ-025 SHALL hold Level, LevelIdx and LevelValid stable until LevelReady=1, and advance k on each handshake.
REQ-026 SHALL go to FIN after the handshake with k=TrailingOnes-1.
REQ-027 SHALL in FIN pulse Done for one cycle with Remaining=TotalCoeff-TrailingOnes, and return to IDLE in the next cycle.
REQ-028 SHALL set SuffixLenInit=1 iff TotalCoeff>10 and TrailingOnes<3; otherwise 0.
REQ-029 SHALL for TotalCoeff=0 produce Done with Remaining=0 and SuffixLenInit=0, with no Consume and no levels.
REQ-030 SHALL ignore TokenValid outside IDLE; back-to-back tokens are separated by at least the FIN cycle.

Reset
REQ-031 SHALL on Rst_n=0 at a clock edge enter IDLE and clear TokenReady→1, Consume, LevelValid, Done and Err to 0, and Level, LevelIdx, Remaining, ConsumeLen and SuffixLenInit to 0.
REQ-032 SHALL abort an in-flight token when reset occurs mid-EMIT, with no Done issued afterward.

Configuration
REQ-033 SHALL with CAVLC_T1_CHECK_EN defined flag a token with TrailingOnes>TotalCoeff or TotalCoeff>16: set Err, drop the token with no Consume/levels/Done, and stay in IDLE.
REQ-034 SHALL without CAVLC_T1_CHECK_EN tie Err to 0 and process every token as given.

Structure
REQ-035 SHALL take the FSM state enum, TC_W=5, MAX_COEFF=16 and the default LEVEL_W from shared package cavlc_pkg.
REQ-036 SHALL be a single module with no sub-module; the sign mapping is inline.

Verification
REQ-037 SHALL verify TotalCoeff=3, TrailingOnes=3, Bits=3'b101 → Consume with ConsumeLen=3, then Levels -1, +1, -1 at idx 0, 1, 2, then Done with Remaining=0 and SuffixLenInit=0.
REQ-038 SHALL verify TotalCoeff=12, TrailingOnes=1, Bits=3'b0xx → one Level +1, then Done with Remaining=11 and SuffixLenInit=1.
REQ-039 SHALL verify TotalCoeff=5, TrailingOnes=0 → no Consume and no LevelValid, with Done one cycle after acceptance and Remaining=5.
REQ-040 SHALL verify LevelReady held low for 4 cycles during TrailingOnes=2 → Level and LevelIdx stable, and TokenReady=0 throughout.
REQ-041 SHALL verify Rst_n=0 after the first level of a TrailingOnes=3 token → IDLE next cycle, all outputs cleared, no Done.
REQ-042 SHALL verify, with CAVLC_T1_CHECK_EN, TotalCoeff=1 and TrailingOnes=2 → Err=1 and sticky, no Consume, no Done.
